nios_ii_system_cpu_debug_cmd_sync: RTL and testbench

//  Parametrised sysclk-side command decoder for the CPU JTAG debug module. Receives update-DR/update-IR

---
 rtl/nios_ii_system_cpu_debug_pkg.sv | 28 ++
 rtl/nios_ii_system_cpu_debug_cmd_fifo.sv | 75 +++++++
 rtl/nios_ii_system_cpu_debug_cmd_sync.sv | 139 +++++++++++++
 tb/tb_nios_ii_system_cpu_debug_cmd_sync.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_ii_system_cpu_debug_pkg.sv
`default_nettype none
// =============================================================================
// nios_ii_system_cpu_debug_pkg: shared IR codes, defaults and helpers for the
// CPU JTAG debug command path.                                      Rev 1.0
// =============================================================================
package nios_ii_system_cpu_debug_pkg;

  typedef enum logic [1:0] {
    IR_OCIMEM    = 2'd0,
    IR_TRACEMEM  = 2'd1,
    IR_BREAK     = 2'd2,
    IR_TRACECTRL = 2'd3
  } ir_code_e;

  localparam int c_DEFAULT_DATA_W  = 38;
  localparam int c_DEFAULT_ACT_BIT = 35;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios_ii_system_cpu_debug_cmd_fifo.sv
`default_nettype none
// =============================================================================
// nios_ii_system_cpu_debug_cmd_fifo: synchronous command FIFO, registered
// level, no write-to-read bypass.                                   Rev 1.0
// =============================================================================
module nios_ii_system_cpu_debug_cmd_fifo
  import nios_ii_system_cpu_debug_pkg::*;
#(
  parameter int  WIDTH = 40,
  parameter int  DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [PTR_W:0]   level_o
);

  localparam logic [PTR_W:0]   c_FULL_LVL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   c_LVL_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic [PTR_W:0]   level_d;
  logic             do_push;
  logic             do_pop;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == c_FULL_LVL);
  assign do_pop  = pop_i & valid_o;
  // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + c_LVL_ONE;
    end else if (!do_push && do_pop) begin
      level_d = level_q - c_LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + c_PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      end
      level_q <= level_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/nios_ii_system_cpu_debug_cmd_sync.sv
`default_nettype none
// =============================================================================
// nios_ii_system_cpu_debug_cmd_sync: sysclk-side JTAG debug command decoder
// with toggle synchronisers, command queue and per-channel pulses.  Rev 1.0
// =============================================================================
module nios_ii_system_cpu_debug_cmd_sync
  import nios_ii_system_cpu_debug_pkg::*;
#(
  parameter int  IR_W        = 2,
  parameter int  DATA_W      = c_DEFAULT_DATA_W,
  parameter int  ACT_BIT     = c_DEFAULT_ACT_BIT,
  parameter int  DEPTH       = 4,
  parameter int  SYNC_STAGES = 2,
  localparam int N_CH        = 2 ** IR_W,
  localparam int LVL_W       = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs_udr_tgl,
  input  logic              vs_uir_tgl,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DATA_W-1:0] sr,
  input  logic              cmd_ready,
  input  logic              clr_ovf,
  output logic              cmd_valid,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [DATA_W-1:0] jdo,
  output logic [N_CH-1:0]   take_action,
  output logic [N_CH-1:0]   take_no_action,
  output logic              ir_update,
  output logic              overflow,
  output logic [LVL_W-1:0]  level
);

  localparam int              c_CMD_W = IR_W + DATA_W;
  localparam logic [N_CH-1:0] c_CH0   = N_CH'(1);

  logic [SYNC_STAGES-1:0] udr_sync_q;
  logic [SYNC_STAGES-1:0] uir_sync_q;
  logic                   udr_dly_q;
  logic                   uir_dly_q;
  logic                   udr_evt;
  logic                   uir_evt;

  logic [c_CMD_W-1:0]     head_cmd;
  logic [IR_W-1:0]        head_ir;
  logic [DATA_W-1:0]      head_data;
  logic                   fifo_full;
  logic                   accept;

  logic [DATA_W-1:0]      jdo_q, jdo_d;
  logic [N_CH-1:0]        take_action_q, take_action_d;
  logic [N_CH-1:0]        take_no_action_q, take_no_action_d;
  logic                   ir_update_q;
  logic                   overflow_q, overflow_d;

  // Each toggle inversion becomes one clk pulse after the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_dly_q  <= 1'b0;
      uir_dly_q  <= 1'b0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr_tgl};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir_tgl};
      udr_dly_q  <= udr_sync_q[SYNC_STAGES-1];
      uir_dly_q  <= uir_sync_q[SYNC_STAGES-1];
    end
  end

  assign udr_evt = udr_sync_q[SYNC_STAGES-1] ^ udr_dly_q;
  assign uir_evt = uir_sync_q[SYNC_STAGES-1] ^ uir_dly_q;

  nios_ii_system_cpu_debug_cmd_fifo #(
    .WIDTH (c_CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (udr_evt),
    .pop_i   (cmd_ready),
    .wdata_i ({ir_in, sr}),
    .rdata_o (head_cmd),
    .valid_o (cmd_valid),
    .full_o  (fifo_full),
    .level_o (level)
  );

  assign head_ir   = head_cmd[c_CMD_W-1:DATA_W];
  assign head_data = head_cmd[DATA_W-1:0];
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    jdo_d            = jdo_q;
    take_action_d    = '0;
    take_no_action_d = '0;
    overflow_d       = overflow_q;
    if (accept) begin
      jdo_d = head_data;
      if (head_data[ACT_BIT]) begin
        take_action_d = c_CH0 << head_ir;
      end else begin
        take_no_action_d = c_CH0 << head_ir;
      end
    end
    // A dropped push wins over a clear in the same cycle.
    if (udr_evt && fifo_full && !accept) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jdo_q            <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      ir_update_q      <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      jdo_q            <= jdo_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      ir_update_q      <= uir_evt;
      overflow_q       <= overflow_d;
    end
  end

  assign cmd_ir         = head_ir;
  assign jdo            = jdo_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign ir_update      = ir_update_q;
  assign overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_ii_system_cpu_debug_cmd_sync.sv
`default_nettype none
// Bench for nios_ii_system_cpu_debug_cmd_sync: directed steps then random traffic
// compared against a queue-based transaction model.
module tb_nios_ii_system_cpu_debug_cmd_sync;

  localparam int S   = 2;
  localparam int DW  = 38;
  localparam int AB  = 35;
  localparam int DEP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          udr = 1'b0, uir = 1'b0, ready = 1'b0, clr = 1'b0;
  logic [1:0]    ir = '0;
  logic [DW-1:0] sr = '0;
  logic          a_valid, a_iru, a_ovf;
  logic [1:0]    a_ir;
  logic [DW-1:0] a_jdo;
  logic [3:0]    a_ta, a_tna;
  logic [2:0]    a_lvl;

  logic          b_udr = 1'b0, b_uir = 1'b0, b_ready = 1'b0, b_clr = 1'b0;
  logic [2:0]    b_irin = '0;
  logic [DW-1:0] b_sr = '0;
  logic          b_valid, b_iru, b_ovf;
  logic [2:0]    b_ir;
  logic [DW-1:0] b_jdo;
  logic [7:0]    b_ta, b_tna;
  logic [3:0]    b_lvl;

  nios_ii_system_cpu_debug_cmd_sync dut_a (
    .clk(clk), .reset(reset), .vs_udr_tgl(udr), .vs_uir_tgl(uir), .ir_in(ir), .sr(sr),
    .cmd_ready(ready), .clr_ovf(clr), .cmd_valid(a_valid), .cmd_ir(a_ir), .jdo(a_jdo),
    .take_action(a_ta), .take_no_action(a_tna), .ir_update(a_iru), .overflow(a_ovf),
    .level(a_lvl)
  );

  nios_ii_system_cpu_debug_cmd_sync #(.IR_W(3), .DEPTH(8)) dut_b (
    .clk(clk), .reset(reset), .vs_udr_tgl(b_udr), .vs_uir_tgl(b_uir), .ir_in(b_irin), .sr(b_sr),
    .cmd_ready(b_ready), .clr_ovf(b_clr), .cmd_valid(b_valid), .cmd_ir(b_ir), .jdo(b_jdo),
    .take_action(b_ta), .take_no_action(b_tna), .ir_update(b_iru), .overflow(b_ovf),
    .level(b_lvl)
  );

  typedef struct packed { logic [1:0] ir; logic [DW-1:0] data; } cmd_t;
  typedef struct { int due; cmd_t c; } evt_t;

  cmd_t          q[$];
  evt_t          pend[$];
  int            uir_due[$];
  int            cyc = 0, last_udr = -100, last_uir = -100;
  logic [3:0]    m_ta = '0, m_tna = '0;
  logic          m_iru = 1'b0, m_ovf = 1'b0;
  logic [DW-1:0] m_jdo = '0;
  int            vectors = 0, miscompares = 0;
  int            npulse;

  logic [DW-1:0] t1 = 38'h0B_DEAD_BEEF;
  logic [DW-1:0] t2 = 38'h07_1234_5678;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: an event lands S+1 edges after its toggle is driven.
  task automatic model_update();
    cmd_t h;
    bit   drop;
    cyc++;
    m_ta  = '0;
    m_tna = '0;
    m_iru = 1'b0;
    if (reset) begin
      q.delete();
      pend.delete();
      uir_due.delete();
      m_jdo = '0;
      m_ovf = 1'b0;
    end else begin
      if (q.size() > 0 && ready) begin
        h     = q.pop_front();
        m_jdo = h.data;
        if (h.data[AB]) m_ta[h.ir] = 1'b1;
        else            m_tna[h.ir] = 1'b1;
      end
      drop = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        h = pend[0].c;
        void'(pend.pop_front());
        if (q.size() < DEP) q.push_back(h);
        else                drop = 1'b1;
      end
      if (drop)     m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (uir_due.size() > 0 && uir_due[0] == cyc) begin
        void'(uir_due.pop_front());
        m_iru = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("level", a_lvl, q.size());
    chk("cmd_valid", a_valid, q.size() > 0);
    chk("overflow", a_ovf, m_ovf);
    chk("take_action", a_ta, m_ta);
    chk("take_no_action", a_tna, m_tna);
    chk("ir_update", a_iru, m_iru);
    chk("jdo", a_jdo, m_jdo);
    if (q.size() > 0) chk("cmd_ir", a_ir, q[0].ir);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic fire_udr(input logic [1:0] i, input logic [DW-1:0] d);
    evt_t e;
    ir  = i;
    sr  = d;
    udr = ~udr;
    e.due    = cyc + S + 1;
    e.c.ir   = i;
    e.c.data = d;
    pend.push_back(e);
    last_udr = cyc;
  endtask

  task automatic fire_uir();
    uir = ~uir;
    uir_due.push_back(cyc + S + 1);
    last_uir = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    udr   = 1'b0;
    uir   = 1'b0;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  initial begin
    step();
    step();
    chk("rst_level", a_lvl, 3'd0);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_b_level", b_lvl, 4'd0);
    reset = 1'b0;
    step();

    // Single action command on channel 2
    ready = 1'b1;
    fire_udr(2'd2, t1);
    repeat (3) step();
    chk("t1_valid", a_valid, 1'b1);
    chk("t1_ta_early", a_ta, 4'b0000);
    step();
    chk("t1_ta", a_ta, 4'b0100);
    chk("t1_jdo", a_jdo, t1);
    step();
    chk("t1_ta_once", a_ta, 4'b0000);

    // No-action command on channel 0
    fire_udr(2'd0, t2);
    repeat (4) step();
    chk("t2_tna", a_tna, 4'b0001);
    chk("t2_ta", a_ta, 4'b0000);
    step();
    chk("t2_tna_once", a_tna, 4'b0000);

    // Burst under backpressure, then overflow on the fifth
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fire_udr(2'(k), rand_data());
      repeat (6) step();
    end
    chk("t3_level4", a_lvl, 3'd4);
    chk("t3_no_ovf", a_ovf, 1'b0);
    fire_udr(2'd1, rand_data());
    repeat (6) step();
    chk("t3_ovf", a_ovf, 1'b1);
    chk("t3_level_held", a_lvl, 3'd4);
    ready  = 1'b1;
    npulse = 0;
    repeat (8) begin
      step();
      npulse += $countones({a_ta, a_tna});
    end
    chk("t3_pulses", npulse, 4);

    // Overflow clear and update-IR
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_ovf_clr", a_ovf, 1'b0);
    fire_uir();
    repeat (3) step();
    chk("t5_iru", a_iru, 1'b1);
    chk("t5_level", a_lvl, 3'd0);
    step();
    chk("t5_iru_once", a_iru, 1'b0);

    // Full queue with push and accept on the same edge
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fire_udr(2'(3 - k), rand_data());
      repeat (6) step();
    end
    fire_udr(2'd2, rand_data());
    repeat (S) step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t4_level", a_lvl, 3'd4);
    chk("t4_no_ovf", a_ovf, 1'b0);
    chk("t4_pulse", $countones({a_ta, a_tna}), 1);
    repeat (3) step();

    // Reset with commands queued
    ready = 1'b1;
    repeat (6) step();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fire_udr(2'(k + 1), rand_data());
      repeat (6) step();
    end
    chk("t6_level3", a_lvl, 3'd3);
    do_reset();
    chk("t6_level0", a_lvl, 3'd0);
    chk("t6_valid0", a_valid, 1'b0);
    chk("t6_nopulse", {a_ta, a_tna}, 8'h00);
    ready = 1'b1;
    repeat (6) step();

    // Wider IR / deeper FIFO variant
    b_irin  = 3'd5;
    b_sr    = t1;
    b_ready = 1'b1;
    b_udr   = 1'b1;
    repeat (3) step();
    chk("b_valid", b_valid, 1'b1);
    step();
    chk("b_ta", b_ta, 8'b0010_0000);
    chk("b_tna", b_tna, 8'h00);
    chk("b_jdo", b_jdo, t1);
    step();
    chk("b_ta_once", b_ta, 8'h00);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      ready = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        if (cyc - last_udr >= S + 3 && $urandom_range(0, 2) == 0)
          fire_udr(2'($urandom_range(0, 3)), rand_data());
        if (cyc - last_uir >= 2 && $urandom_range(0, 5) == 0)
          fire_uir();
      end
      step();
    end
    clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
